// File: rtl/ping_pong_pkg.sv
// Shared types and default sizes for the ping-pong counter job scheduler.
package ping_pong_pkg;

   localparam int unsigned WIDTH_DEF  = 4;
   localparam int unsigned STEP_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the one
// that did not own the previous job.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last_owner ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/ping_pong_scheduler.sv
// Arbitrates two requesters onto one ping-pong counter, loads its range, and
// runs exactly the requested number of enable cycles before signalling done.
module ping_pong_scheduler
   import ping_pong_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned STEP_W = STEP_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   input  logic [2*WIDTH-1:0]  req_max,
   input  logic [2*WIDTH-1:0]  req_min,
   input  logic [2*STEP_W-1:0] req_steps,
   output logic [1:0]          req_ready,
   input  logic                flip_req,
   output logic                cnt_rst_n,
   output logic                cnt_enable,
   output logic                cnt_flip,
   output logic [WIDTH-1:0]    cnt_max,
   output logic [WIDTH-1:0]    cnt_min,
   output logic                busy,
   output logic                owner,
   output logic [1:0]          done,
   output logic                err
);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    max_q, max_d;
   logic [WIDTH-1:0]    min_q, min_d;
   logic [STEP_W-1:0]   steps_q, steps_d;
   logic [STEP_W-1:0]   remaining_q, remaining_d;
   logic                owner_q, owner_d;
   logic                last_owner_q, last_owner_d;
   logic [1:0]          grant;
   logic                gsel;
   logic                range_bad;

   rr_arbiter2 u_arb (
      .req        (req_valid),
      .last_owner (last_owner_q),
      .grant      (grant)
   );

   assign gsel      = grant[1];
   assign range_bad = (min_q >= max_q);

   // Next-state, job latches and step counter.
   always_comb begin
      state_d      = state_q;
      max_d        = max_q;
      min_d        = min_q;
      steps_d      = steps_q;
      remaining_d  = remaining_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;

      unique case (state_q)
         IDLE: begin
            if (|grant) begin
               state_d = LOAD;
               owner_d = gsel;
               max_d   = gsel ? req_max[2*WIDTH-1:WIDTH]     : req_max[WIDTH-1:0];
               min_d   = gsel ? req_min[2*WIDTH-1:WIDTH]     : req_min[WIDTH-1:0];
               steps_d = gsel ? req_steps[2*STEP_W-1:STEP_W] : req_steps[STEP_W-1:0];
            end
         end
         LOAD: begin
            if (range_bad || (steps_q == '0)) begin
               state_d = DONE;
            end else begin
               remaining_d = steps_q;
               state_d     = RUN;
            end
         end
         RUN: begin
            remaining_d = remaining_q - STEP_W'(1);
            if (remaining_q == STEP_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Round-robin history advances as the job finishes.
      if ((state_d == DONE) && (state_q != DONE)) begin
         last_owner_d = owner_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         max_q        <= '0;
         min_q        <= '0;
         steps_q      <= '0;
         remaining_q  <= '0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         max_q        <= max_d;
         min_q        <= min_d;
         steps_q      <= steps_d;
         remaining_q  <= remaining_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
      end
   end

   // Outputs decode from registered state; ready and flip are the only live paths.
   always_comb begin
      req_ready  = ((state_q == IDLE) && rst_n) ? grant : 2'b00;
      busy       = (state_q != IDLE);
      cnt_rst_n  = (state_q != LOAD);
      cnt_enable = (state_q == RUN);
      cnt_flip   = (state_q == RUN) && flip_req;
      cnt_max    = max_q;
      cnt_min    = min_q;
      owner      = owner_q;
      done       = (state_q == DONE) ? {owner_q, ~owner_q} : 2'b00;
      err        = (state_q == DONE) && range_bad;
   end

endmodule

// File: tb/tb_ping_pong_scheduler.sv
// Directed bench for ping_pong_scheduler with a job-timeline model and an
// attached ping-pong counter model.
module tb_ping_pong_scheduler;

   localparam int unsigned WIDTH  = 4;
   localparam int unsigned STEP_W = 8;

   logic                clk       = 1'b0;
   logic                rst_n     = 1'b0;
   logic [1:0]          req_valid = '0;
   logic [2*WIDTH-1:0]  req_max   = '0;
   logic [2*WIDTH-1:0]  req_min   = '0;
   logic [2*STEP_W-1:0] req_steps = '0;
   logic                flip_req  = 1'b0;
   logic [1:0]          req_ready;
   logic                cnt_rst_n, cnt_enable, cnt_flip;
   logic [WIDTH-1:0]    cnt_max, cnt_min;
   logic                busy, owner, err;
   logic [1:0]          done;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   ping_pong_scheduler #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_max    (req_max),
      .req_min    (req_min),
      .req_steps  (req_steps),
      .req_ready  (req_ready),
      .flip_req   (flip_req),
      .cnt_rst_n  (cnt_rst_n),
      .cnt_enable (cnt_enable),
      .cnt_flip   (cnt_flip),
      .cnt_max    (cnt_max),
      .cnt_min    (cnt_min),
      .busy       (busy),
      .owner      (owner),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_job(input int idx, input int mx, input int mn, input int st);
      req_max[idx*WIDTH +: WIDTH]     = WIDTH'(mx);
      req_min[idx*WIDTH +: WIDTH]     = WIDTH'(mn);
      req_steps[idx*STEP_W +: STEP_W] = STEP_W'(st);
   endtask

   function automatic logic [1:0] arb_f(input logic [1:0] v, input bit last);
      if (v == 2'b11) return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   // Job-timeline model: a job accepted at cycle t has LOAD at t+1, RUN for
   // steps cycles (none if invalid/zero), then one DONE cycle.
   bit               m_active = 1'b0;
   int               m_t      = 0;
   int               m_steps  = 0;
   logic [WIDTH-1:0] m_max    = '0;
   logic [WIDTH-1:0] m_min    = '0;
   bit               m_owner  = 1'b0;
   bit               m_last   = 1'b1;

   always @(negedge clk) begin
      logic [1:0] e_ready, e_done;
      logic       e_rstn, e_en, e_flip, e_busy, e_err;
      int         k, dk;
      bit         bad;
      k = 0; dk = 0; bad = 1'b0;
      e_ready = 2'b00; e_done = 2'b00;
      e_rstn = 1'b1; e_en = 1'b0; e_flip = 1'b0; e_busy = 1'b0; e_err = 1'b0;
      if (!rst_n) begin
         m_active = 1'b0; m_last = 1'b1; m_max = '0; m_min = '0; m_owner = 1'b0;
      end else if (m_active) begin
         bad    = (m_min >= m_max);
         dk     = (bad || m_steps == 0) ? 2 : 2 + m_steps;
         k      = cyc - m_t;
         e_busy = 1'b1;
         if (k == 1) e_rstn = 1'b0;
         else if (k < dk) begin
            e_en   = 1'b1;
            e_flip = flip_req;
         end else begin
            e_done = m_owner ? 2'b10 : 2'b01;
            e_err  = bad;
         end
      end else begin
         e_ready = arb_f(req_valid, m_last);
      end

      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("cnt_rst_n", 32'(cnt_rst_n), 32'(e_rstn));
      chk("cnt_enable", 32'(cnt_enable), 32'(e_en));
      chk("cnt_flip", 32'(cnt_flip), 32'(e_flip));
      chk("cnt_max", 32'(cnt_max), 32'(m_max));
      chk("cnt_min", 32'(cnt_min), 32'(m_min));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));

      if (rst_n) begin
         if (m_active && k == dk) begin
            m_last   = m_owner;
            m_active = 1'b0;
         end else if (!m_active && (req_valid & e_ready) != 2'b00) begin
            m_active = 1'b1;
            m_t      = cyc;
            m_owner  = e_ready[1];
            m_max    = req_max[int'(m_owner)*WIDTH +: WIDTH];
            m_min    = req_min[int'(m_owner)*WIDTH +: WIDTH];
            m_steps  = int'(req_steps[int'(m_owner)*STEP_W +: STEP_W]);
         end
      end
   end

   // Attached counter: clear loads min going up, bounce at the range ends.
   logic [WIDTH-1:0] c_val = '0;
   bit               c_up  = 1'b1;
   int               cnt_log[$];

   always @(negedge clk) begin
      if (!cnt_rst_n) begin
         c_val = cnt_min;
         c_up  = 1'b1;
      end else if (cnt_enable) begin
         if (cnt_flip) c_up = !c_up;
         if (c_up && c_val >= cnt_max) c_up = 1'b0;
         else if (!c_up && c_val <= cnt_min) c_up = 1'b1;
         c_val = c_up ? c_val + 1'b1 : c_val - 1'b1;
         cnt_log.push_back(int'(c_val));
      end
   end

   initial begin
      int exp_seq[6];
      int nflip;
      exp_seq = '{3, 4, 5, 4, 3, 2};

      // Reset held with random inputs.
      repeat (4) begin
         tick();
         req_valid = 2'($urandom);
         req_max   = 8'($urandom);
         req_min   = 8'($urandom);
         req_steps = 16'($urandom);
         flip_req  = 1'($urandom);
         #1;
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_ready", 32'(req_ready), 32'd0);
      end
      tick();
      req_valid = '0; req_max = '0; req_min = '0; req_steps = '0; flip_req = 1'b0;
      rst_n = 1'b1;

      // Single job from requester 0.
      tick();
      cnt_log.delete();
      set_job(0, 5, 2, 6);
      req_valid = 2'b01;
      #1 chk("single_ready_T", 32'(req_ready), 32'h1);
      tick(); req_valid = 2'b00;
      chk("single_clear_T1", 32'(cnt_rst_n), 32'd0);
      tick();
      chk("single_clear_T2", 32'(cnt_rst_n), 32'd1);
      chk("single_en_T2", 32'(cnt_enable), 32'd1);
      repeat (6) tick();
      chk("single_done_T8", 32'(done), 32'h1);
      chk("single_en_T8", 32'(cnt_enable), 32'd0);
      chk("single_log_len", 32'(cnt_log.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < cnt_log.size()) chk("single_counter_seq", 32'(cnt_log[i]), 32'(exp_seq[i]));
      end
      tick();

      // Fresh reset so the first tie goes to requester 0.
      rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      tick();

      // Tie with both requesters held valid.
      set_job(0, 9, 1, 2);
      set_job(1, 9, 1, 2);
      req_valid = 2'b11;
      #1 chk("tie_grant1", 32'(req_ready), 32'h1);
      tick();
      chk("tie_owner1", 32'(owner), 32'd0);
      chk("tie_busy_ready", 32'(req_ready), 32'h0);
      repeat (4) tick();
      chk("tie_grant2", 32'(req_ready), 32'h2);
      tick();
      chk("tie_owner2", 32'(owner), 32'd1);
      repeat (4) tick();
      chk("tie_grant3", 32'(req_ready), 32'h1);
      tick(); req_valid = 2'b00;
      chk("tie_owner3", 32'(owner), 32'd0);
      repeat (5) tick();

      // Invalid range from requester 1.
      set_job(1, 3, 3, 4);
      req_valid = 2'b10;
      tick(); req_valid = 2'b00;
      tick();
      chk("inv_done_T2", 32'(done), 32'h2);
      chk("inv_err_T2", 32'(err), 32'd1);
      chk("inv_en_T2", 32'(cnt_enable), 32'd0);
      tick();
      chk("inv_idle_T3", 32'(busy), 32'd0);

      // flip_req held through a three-step job.
      set_job(0, 7, 0, 3);
      flip_req  = 1'b1;
      req_valid = 2'b01;
      nflip = 0;
      for (int i = 0; i < 7; i++) begin
         #1;
         if (cnt_flip) nflip++;
         tick();
         req_valid = 2'b00;
      end
      chk("flip_cycles", 32'(nflip), 32'd3);
      flip_req = 1'b0;

      // Async reset in the middle of an eight-step job.
      set_job(0, 9, 0, 8);
      req_valid = 2'b01;
      tick(); req_valid = 2'b00;
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("arst_en", 32'(cnt_enable), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      set_job(0, 6, 1, 2);
      set_job(1, 6, 1, 2);
      req_valid = 2'b11;
      #1 chk("arst_tie_grant", 32'(req_ready), 32'h1);
      tick(); req_valid = 2'b00;
      chk("arst_tie_owner", 32'(owner), 32'd0);
      repeat (6) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ping_pong_scheduler.md
# ping_pong_scheduler

Job scheduler for one shared parameterized ping-pong counter. Two requesters each submit a job (range max/min plus a count of enable cycles) over a valid/ready handshake. The block arbitrates round-robin, loads the range, clears the counter, and drives exactly the requested number of enable cycles. It then pulses done back to the owning requester. It sits between requester logic and the counter's clk/rst_n/enable/flip/max/min pins.

## Interface
- WIDTH, 4, counter data width (max/min/out)
- STEP_W, 8, width of the job step count
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  requester i has a job pending
- req_max  in  2*WIDTH  requester i max at [i*WIDTH +: WIDTH]
- req_min  in  2*WIDTH  requester i min, same packing
- req_steps  in  2*STEP_W  requester i enable-cycle count, packed likewise
- req_ready  out  2  one-hot; job i accepted when req_valid[i] & req_ready[i]
- flip_req  in  1  external flip request, forwarded only while running
- cnt_rst_n  out  1  synchronous active-low clear to counter
- cnt_enable  out  1  counter enable
- cnt_flip  out  1  counter flip
- cnt_max, cnt_min  out  WIDTH each  latched job range
- busy  out  1  high in any state but IDLE
- owner  out  1  index of requester whose job is active
- done  out  2  one-cycle pulse to owner at job end
- err  out  1  one-cycle pulse with done when job range was invalid

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req_valid is high, the arbiter grants one requester g and req_ready[g]=1 combinationally.
  - On the handshake, latch req_max/min/steps[g] and owner=g, then go to LOAD.
  - No request pending: stay in IDLE.
- Arbitration:
  - Single valid requester wins.
  - Both valid: the requester that is not last_owner wins.
  - last_owner resets to 1, so requester 0 wins the first tie.
  - last_owner updates on entering DONE.
- LOAD:
  - cnt_rst_n=0 for exactly one cycle; the counter loads min and sets direction up.
  - Invalid job (latched min >= max) or steps==0: go to DONE.
  - Otherwise load remaining=steps and go to RUN.
- RUN:
  - cnt_enable=1 every cycle; remaining decrements each cycle.
  - cnt_flip = flip_req.
  - When remaining==1, next state is DONE, giving exactly steps enable cycles.
- DONE:
  - done[owner]=1; err=1 if the job was invalid.
  - Next state is IDLE.
- Outside RUN: cnt_enable=0 and cnt_flip=0; flip_req is ignored.
- Requester inputs are ignored after acceptance until the block returns to IDLE.
- Reset values:
  - State: IDLE.
  - Outputs: req_ready=0, cnt_rst_n=1, cnt_enable=0, cnt_flip=0, cnt_max=0, cnt_min=0, busy=0, owner=0, done=0, err=0.
  - Internal: last_owner=1, remaining=0.
- Asserting rst_n mid-job drops to IDLE immediately. The job is lost and no done pulse is issued.

## Timing
- Accept at cycle T. LOAD at T+1. RUN at T+2..T+1+N for steps=N. DONE at T+2+N. IDLE at T+3+N.
- The earliest next accept is at T+3+N.
- Invalid or zero-step job: LOAD at T+1, DONE at T+2.
- All outputs are decoded from registered state/latches.
- Only two combinational input-to-output paths exist: req_valid -> req_ready in IDLE, and flip_req -> cnt_flip in RUN.
- remaining is STEP_W bits and never wraps, because decrement happens only while remaining >= 1.

## Structure
- Package ping_pong_pkg holds:
  - State enum (IDLE, LOAD, RUN, DONE).
  - Default WIDTH and STEP_W constants.
- Sub-module rr_arbiter2: a two-way round-robin arbiter.
  - Inputs: req[1:0], last_owner.
  - Output: one-hot grant.
- FSM, latches and step counter live in ping_pong_scheduler.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs at reset values, busy=0, req_ready=0.
- Single job, req0 max=5 min=2 steps=6, accepted at T:
  - cnt_rst_n=0 at T+1 only.
  - cnt_enable=1 at T+2..T+7.
  - done[0] at T+8.
  - Attached counter reads 3,4,5,4,3,2.
- Tie: both req_valid held with steps=2:
  - First grant is requester 0 and owner=0; second grant is requester 1 and owner=1.
  - Third grant is 0 again; no grant while busy.
- Invalid range, req1 max=3 min=3 steps=4 at T -> no enable, done[1]=1 and err=1 at T+2.
- flip_req=1 held through a steps=3 job -> cnt_flip=1 only in the 3 RUN cycles, 0 in IDLE/LOAD/DONE.
- Asynchronous reset asserted at T+4 of an 8-step job:
  - cnt_enable=0 before the next edge, state is IDLE, and done is never pulsed.
  - A new request after release is accepted with requester 0 winning the tie.
